// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared stage control record, default reset value and count-width helper for dff_pipe (parity field only with DFF_PIPE_PARITY_EN)
package dff_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = 8'h00;
  typedef struct packed {
    logic valid;
`ifdef DFF_PIPE_PARITY_EN
    logic par;
`endif
  } stage_ctl_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline register (data + valid/parity), async active-low reset, sync clr, en hold; ports clk reset_n en clr d d_ctl -> q q_ctl
module dff_stage import dff_pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  stage_ctl_t       d_ctl,
  output logic [WIDTH-1:0] q,
  output stage_ctl_t       q_ctl
);
  logic [WIDTH-1:0] data_q, data_d;
  stage_ctl_t ctl_q, ctl_d;
  always_comb begin
    data_d = clr ? RESET_VAL : en ? d : data_q;
    ctl_d = clr ? '0 : en ? d_ctl : ctl_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VAL;
      ctl_q <= '0;
    end else begin
      data_q <= data_d;
      ctl_q <= ctl_d;
    end
  end
  assign q = data_q;
  assign q_ctl = ctl_q;
endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH delay line; in clk reset_n en clr d d_valid, out q qb q_valid count (+par_err with DFF_PIPE_PARITY_EN)
module dff_pipe import dff_pipe_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             q_valid,
  output logic [CNT_W-1:0] count
`ifdef DFF_PIPE_PARITY_EN
  ,
  output logic             par_err
`endif
);
  logic [WIDTH-1:0] data [DEPTH];
  stage_ctl_t ctl [DEPTH];
  stage_ctl_t in_ctl;
  logic [CNT_W-1:0] count_q, count_d;
  always_comb begin
    in_ctl = '0;
    in_ctl.valid = d_valid;
`ifdef DFF_PIPE_PARITY_EN
    in_ctl.par = ^d;
`endif
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
        .d(d), .d_ctl(in_ctl), .q(data[i]), .q_ctl(ctl[i])
      );
    end else begin : g_body
      dff_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr),
        .d(data[i-1]), .d_ctl(ctl[i-1]), .q(data[i]), .q_ctl(ctl[i])
      );
    end
  end
  assign q = data[DEPTH-1];
  assign qb = ~data[DEPTH-1];
  assign q_valid = ctl[DEPTH-1].valid;
  // entering and leaving items cancel, so a full pipe with d_valid stays at DEPTH
  always_comb count_d = clr ? '0 : en ? count_q + CNT_W'(d_valid) - CNT_W'(q_valid) : count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign count = count_q;
`ifdef DFF_PIPE_PARITY_EN
  logic err_q, err_d;
  always_comb err_d = clr ? 1'b0 : q_valid & (^data[DEPTH-1] ^ ctl[DEPTH-1].par);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign par_err = err_q;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4, RESET_VAL=0)
module tb_dff_pipe;
  import dff_pipe_pkg::*;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = cnt_width(DEPTH);
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic d_valid = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] q, qb;
  logic q_valid;
  logic [CNT_W-1:0] count;
  int total = 0;
  int bad = 0;
`ifdef DFF_PIPE_PARITY_EN
  logic par_err;
`endif
  always #5 clk = ~clk;
  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q), .qb(qb), .q_valid(q_valid), .count(count)
`ifdef DFF_PIPE_PARITY_EN
    , .par_err(par_err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [7:0] qe, input logic ve, input int ce);
    logic [7:0] qbe;
    qbe = ~qe;
    chk({tag, ".q"}, 32'(q), 32'(qe));
    chk({tag, ".qb"}, 32'(qb), 32'(qbe));
    chk({tag, ".v"}, 32'(q_valid), 32'(ve));
    chk({tag, ".cnt"}, 32'(count), 32'(ce));
  endtask
  task automatic tick(input logic e, input logic c, input logic [7:0] dd, input logic dv);
    en = e;
    clr = c;
    d = dd;
    d_valid = dv;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int seq_cnt [10];
    seq_cnt = '{1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
    repeat (3) @(negedge clk);
    chk_out("rst", 8'h00, 1'b0, 0);
    reset_n = 1'b1;
    tick(1'b1, 1'b0, 8'hA5, 1'b1);
    chk_out("a5_e1", 8'h00, 1'b0, 1);
    for (int k = 2; k <= 3; k++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      chk_out($sformatf("a5_e%0d", k), 8'h00, 1'b0, 1);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("a5_e4", 8'hA5, 1'b1, 1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("a5_e5", 8'h00, 1'b0, 0);
    for (int k = 1; k <= 10; k++) begin
      logic dv;
      logic ve;
      dv = (k <= 6);
      ve = (k >= 4 && k <= 9);
      tick(1'b1, 1'b0, dv ? 8'(k) : 8'h00, dv);
      chk_out($sformatf("seq_e%0d", k), ve ? 8'(k - 3) : 8'h00, ve, seq_cnt[k-1]);
    end
    tick(1'b1, 1'b0, 8'h11, 1'b1);
    tick(1'b1, 1'b0, 8'h22, 1'b1);
    chk_out("stall_pre", 8'h00, 1'b0, 2);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 8'hFF, 1'b1);
      chk_out($sformatf("stall%0d", k), 8'h00, 1'b0, 2);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("resume1", 8'h00, 1'b0, 2);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("resume2", 8'h11, 1'b1, 2);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("resume3", 8'h22, 1'b1, 1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("resume4", 8'h00, 1'b0, 0);
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, 8'(8'h30 + k), 1'b1);
    chk_out("full", 8'h31, 1'b1, 4);
    tick(1'b1, 1'b1, 8'h55, 1'b1);
    chk_out("clr", 8'h00, 1'b0, 0);
    tick(1'b1, 1'b0, 8'h77, 1'b1);
    chk_out("post_clr1", 8'h00, 1'b0, 1);
    for (int k = 2; k <= 3; k++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b0);
      chk_out($sformatf("post_clr%0d", k), 8'h00, 1'b0, 1);
    end
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("post_clr4", 8'h77, 1'b1, 1);
    tick(1'b0, 1'b1, 8'h00, 1'b1);
    chk_out("clr_no_en", 8'h00, 1'b0, 0);
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, 8'h99, 1'b1);
    chk_out("pre_arst", 8'h99, 1'b1, 4);
    #2 reset_n = 1'b0;
    #1 chk_out("arst", 8'h00, 1'b0, 0);
    @(negedge clk);
    tick(1'b1, 1'b0, 8'h99, 1'b1);
    chk_out("arst_hold", 8'h00, 1'b0, 0);
    reset_n = 1'b1;
`ifdef DFF_PIPE_PARITY_EN
    chk("par_rst", 32'(par_err), 32'd0);
    tick(1'b1, 1'b0, 8'hA5, 1'b1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    force dut.g_stage[2].g_body.u_stage.data_q = 8'hAD;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    release dut.g_stage[2].g_body.u_stage.data_q;
    chk("par_arrive", 32'(par_err), 32'd0);
    chk_out("par_word", 8'hAD, 1'b1, 1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_err", 32'(par_err), 32'd1);
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    chk("par_clr", 32'(par_err), 32'd0);
    tick(1'b1, 1'b0, 8'h3C, 1'b1);
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk_out("par_good", 8'h3C, 1'b1, 1);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("par_ok", 32'(par_err), 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
